zipdbg_sequencer: RTL and testbench

//  Host-side master for the ZipCPU debug slave port (control word at addr 0, data word at addr 1).

---
 rtl/zipdbg_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_zipdbg_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zipdbg_sequencer.sv
// Host-side master for the ZipCPU debug slave port: expands one register-level
// request into the halt / poll / data-access bus sequence and reports the result.
module zipdbg_sequencer #(
  parameter int unsigned POLL_LIMIT  = 16,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // Host request / response
  input  logic        i_req_stb,
  input  logic [1:0]  i_req_op,
  input  logic [4:0]  i_req_reg,
  input  logic [31:0] i_req_data,
  output logic        o_req_busy,
  output logic        o_rsp_stb,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  // CPU debug bus
  output logic        o_dbg_cyc,
  output logic        o_dbg_stb,
  output logic        o_dbg_we,
  output logic        o_dbg_addr,
  output logic [31:0] o_dbg_data,
  input  logic        i_dbg_ack,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTL_WR,
    S_POLL,
    S_POLL_CHK,
    S_DATA,
    S_RAW_WR,
    S_STAT_RD,
    S_RESP
  } state_t;

  localparam logic [1:0]  OP_REG_RD  = 2'b00;
  localparam logic [1:0]  OP_REG_WR  = 2'b01;
  localparam logic [1:0]  OP_RAW_WR  = 2'b10;
  localparam logic [1:0]  OP_STAT_RD = 2'b11;
  localparam logic [31:0] CTL_HALT   = 32'h0000_0400;
  localparam int          READY_BIT  = 9;
  localparam logic [7:0]  POLL_LAST  = 8'(POLL_LIMIT - 1);
  localparam logic [11:0] ACK_LAST   = 12'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic        r_active;
  logic [1:0]  r_op;
  logic [4:0]  r_reg;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_poll_cnt;
  logic [11:0] r_ack_cnt;

  logic        w_is_access;
  logic        w_acc_we;
  logic        w_acc_addr;
  logic [31:0] w_acc_data;
  state_t      w_after_ack;

  // Per-state bus access attributes, shared by one common access engine below.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_is_access = 1'b1;
    w_acc_we    = 1'b0;
    w_acc_addr  = 1'b0;
    w_acc_data  = '0;
    w_after_ack = S_RESP;
    case (r_state)
      S_CTL_WR: begin
        w_acc_we    = 1'b1;
        w_acc_data  = CTL_HALT | {27'h0, r_reg};
        w_after_ack = S_POLL;
      end
      S_POLL:    w_after_ack = S_POLL_CHK;
      S_DATA: begin
        w_acc_we   = (r_op == OP_REG_WR);
        w_acc_addr = 1'b1;
        w_acc_data = r_wdata;
      end
      S_RAW_WR: begin
        w_acc_we   = 1'b1;
        w_acc_data = r_wdata;
      end
      S_STAT_RD: w_acc_we = 1'b0;
      default:   w_is_access = 1'b0;
    endcase
  end

  // NOTE: reset is asynchronous so a mid-sequence abort drops cyc/stb at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_active   <= 1'b0;
      r_op       <= '0;
      r_reg      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
      r_ack_cnt  <= '0;
      o_req_busy <= 1'b0;
      o_rsp_stb  <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      o_dbg_cyc  <= 1'b0;
      o_dbg_stb  <= 1'b0;
      o_dbg_we   <= 1'b0;
      o_dbg_addr <= 1'b0;
      o_dbg_data <= '0;
    end else if (w_is_access) begin
      // The first cycle of each access state keeps cyc low, giving the idle gap.
      if (!r_active) begin
        r_active   <= 1'b1;
        r_ack_cnt  <= '0;
        o_dbg_cyc  <= 1'b1;
        o_dbg_stb  <= 1'b1;
        o_dbg_we   <= w_acc_we;
        o_dbg_addr <= w_acc_addr;
        o_dbg_data <= w_acc_data;
      end else begin
        if (o_dbg_stb && !i_dbg_stall) begin
          o_dbg_stb <= 1'b0;
        end
        if (i_dbg_ack) begin
          o_dbg_cyc <= 1'b0;
          o_dbg_stb <= 1'b0;
          r_active  <= 1'b0;
          r_state   <= w_after_ack;
          if (!o_dbg_we) begin
            r_rdata <= i_dbg_data;
          end
        end else if (r_ack_cnt == ACK_LAST) begin
          o_dbg_cyc <= 1'b0;
          o_dbg_stb <= 1'b0;
          r_active  <= 1'b0;
          r_err     <= 1'b1;
          r_state   <= S_RESP;
        end else begin
          r_ack_cnt <= r_ack_cnt + 12'd1;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // busy is still high during the o_rsp_stb cycle, so requests there are ignored
          o_rsp_stb  <= 1'b0;
          o_req_busy <= 1'b0;
          if (i_req_stb && !o_req_busy) begin
            o_req_busy <= 1'b1;
            r_op       <= i_req_op;
            r_reg      <= i_req_reg;
            r_wdata    <= i_req_data;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_poll_cnt <= '0;
            r_active   <= 1'b0;
            case (i_req_op)
              OP_REG_RD, OP_REG_WR: r_state <= S_CTL_WR;
              OP_RAW_WR:            r_state <= S_RAW_WR;
              default:              r_state <= S_STAT_RD;
            endcase
          end
        end
        S_POLL_CHK: begin
          if (r_rdata[READY_BIT]) begin
            r_state <= S_DATA;
          end else if (r_poll_cnt == POLL_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_poll_cnt <= r_poll_cnt + 8'd1;
            r_state    <= S_POLL;
          end
        end
        S_RESP: begin
          o_rsp_stb <= 1'b1;
          o_rsp_err <= r_err;
          if (r_err || r_op == OP_REG_WR || r_op == OP_RAW_WR) begin
            o_rsp_data <= '0;
          end else begin
            o_rsp_data <= r_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // OP_STAT_RD only selects the default branch of the request decode.
  logic w_unused_op;
  assign w_unused_op = (OP_STAT_RD == 2'b11);

endmodule

// File: tb/tb_zipdbg_sequencer.sv
// Self-checking bench for zipdbg_sequencer: a behavioural debug-port slave plus a
// transaction-level reference model of the expected bus sequence and response.
module tb_zipdbg_sequencer;

  localparam int POLL_LIMIT  = 16;
  localparam int ACK_TIMEOUT = 1023;
  localparam int BUDGET      = 5000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_stb;
  logic [1:0]  i_req_op;
  logic [4:0]  i_req_reg;
  logic [31:0] i_req_data;
  logic        o_req_busy;
  logic        o_rsp_stb;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_dbg_cyc;
  logic        o_dbg_stb;
  logic        o_dbg_we;
  logic        o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        i_dbg_ack;
  logic        i_dbg_stall;
  logic [31:0] i_dbg_data;

  zipdbg_sequencer #(.POLL_LIMIT(POLL_LIMIT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_stb(i_req_stb), .i_req_op(i_req_op), .i_req_reg(i_req_reg), .i_req_data(i_req_data),
    .o_req_busy(o_req_busy), .o_rsp_stb(o_rsp_stb), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_dbg_cyc(o_dbg_cyc), .o_dbg_stb(o_dbg_stb), .o_dbg_we(o_dbg_we), .o_dbg_addr(o_dbg_addr),
    .o_dbg_data(o_dbg_data), .i_dbg_ack(i_dbg_ack), .i_dbg_stall(i_dbg_stall), .i_dbg_data(i_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        we;
    logic        addr;
    logic [31:0] data;
  } txn_t;

  int checks = 0;
  int failures = 0;

  // Slave configuration and observation
  txn_t        log_q[$];
  int          stb_len_q[$];
  logic [31:0] status_q[$];
  int          cfg_stall = 0;
  bit          cfg_noack = 1'b0;
  logic [31:0] cfg_data1 = 32'h0;
  int          gap_err = 0;
  int          last_cyc_run = 0;
  int          rsp_count = 0;

  bit          s_in_stb = 1'b0;
  bit          s_prev_cyc = 1'b0;
  int          s_stall_left = 0;
  int          s_stb_cycles = 0;
  int          s_cyc_run = 0;

  // Expected results from the reference model
  txn_t        exp_q[$];
  logic [31:0] exp_data;
  logic        exp_err;

  // Debug-port slave: status reads pop status_q (default 0x200), data reads return cfg_data1.
  initial begin
    txn_t t;
    i_dbg_ack = 1'b0; i_dbg_stall = 1'b0; i_dbg_data = '0;
    forever begin
      @(posedge i_clk); #1;
      i_dbg_ack = 1'b0; i_dbg_stall = 1'b0; i_dbg_data = '0;
      if (o_rsp_stb) rsp_count++;
      if (o_dbg_cyc) s_cyc_run++;
      else begin
        if (s_cyc_run != 0) last_cyc_run = s_cyc_run;
        s_cyc_run = 0;
      end
      if (o_dbg_cyc && o_dbg_stb) begin
        if (!s_in_stb) begin
          s_in_stb = 1'b1;
          s_stall_left = cfg_stall;
          s_stb_cycles = 0;
          if (s_prev_cyc) gap_err++;
        end
        s_stb_cycles++;
        if (s_stall_left > 0) begin
          i_dbg_stall = 1'b1;
          s_stall_left--;
        end else begin
          t.we = o_dbg_we; t.addr = o_dbg_addr; t.data = o_dbg_we ? o_dbg_data : 32'h0;
          log_q.push_back(t);
          stb_len_q.push_back(s_stb_cycles);
          if (!cfg_noack) begin
            i_dbg_ack = 1'b1;
            if (!o_dbg_we) begin
              if (o_dbg_addr) i_dbg_data = cfg_data1;
              else if (status_q.size() != 0) i_dbg_data = status_q.pop_front();
              else i_dbg_data = 32'h200;
            end
          end
        end
      end else begin
        s_in_stb = 1'b0;
      end
      s_prev_cyc = o_dbg_cyc;
    end
  end

  // Reference model: the bus transactions and response a request should produce,
  // given the status words the slave will return.
  function automatic void build_expect(input logic [1:0] op, input logic [4:0] rg,
                                       input logic [31:0] d, input logic [31:0] d1);
    txn_t t;
    logic [31:0] st;
    bit ready;
    exp_q.delete();
    exp_data = 32'h0;
    exp_err  = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        t = '{we: 1'b1, addr: 1'b0, data: 32'h400 + {27'h0, rg}};
        exp_q.push_back(t);
        ready = 1'b0;
        for (int k = 0; k < POLL_LIMIT && !ready; k++) begin
          t = '{we: 1'b0, addr: 1'b0, data: 32'h0};
          exp_q.push_back(t);
          st = (k < status_q.size()) ? status_q[k] : 32'h200;
          ready = st[9];
        end
        if (ready) begin
          t = '{we: (op == 2'b01), addr: 1'b1, data: (op == 2'b01) ? d : 32'h0};
          exp_q.push_back(t);
          exp_data = (op == 2'b00) ? d1 : 32'h0;
        end else begin
          exp_err = 1'b1;
        end
      end
      2'b10: begin
        t = '{we: 1'b1, addr: 1'b0, data: d};
        exp_q.push_back(t);
      end
      default: begin
        t = '{we: 1'b0, addr: 1'b0, data: 32'h0};
        exp_q.push_back(t);
        exp_data = (status_q.size() != 0) ? status_q[0] : 32'h200;
      end
    endcase
  endfunction

  // Issues one request when idle and waits (bounded) for its response.
  task automatic do_req(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int lat, output bit got);
    int n;
    got = 1'b0; rdata = '0; err = 1'b0; lat = 0; n = 0;
    while (o_req_busy && n < BUDGET) begin
      @(posedge i_clk); #1; n++;
    end
    log_q.delete();
    stb_len_q.delete();
    i_req_op = op; i_req_reg = rg; i_req_data = d; i_req_stb = 1'b1;
    @(posedge i_clk); #1;
    i_req_stb = 1'b0;
    lat = 1;
    while (!got && lat < BUDGET) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_rsp_stb) begin
        got = 1'b1; rdata = o_rsp_data; err = o_rsp_err;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_stb = 1'b0; i_req_op = '0; i_req_reg = '0; i_req_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_req_busy, o_rsp_stb, o_rsp_err, o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {o_req_busy, o_rsp_stb, o_rsp_err, o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr});
    end
    checks++;
    if (o_rsp_data !== 32'h0 || o_dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: rsp_data=%h dbg_data=%h want 0", o_rsp_data, o_dbg_data);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reg_read();
    logic [31:0] rd; logic er; int lat; bit got;
    txn_t w0, r0, r1;
    w0 = '{we: 1'b1, addr: 1'b0, data: 32'h405};
    r0 = '{we: 1'b0, addr: 1'b0, data: 32'h0};
    r1 = '{we: 1'b0, addr: 1'b1, data: 32'h0};
    status_q.delete(); status_q.push_back(32'h200);
    cfg_data1 = 32'h12345678; cfg_stall = 0;
    do_req(2'b00, 5'd5, 32'h0, rd, er, lat, got);
    checks++;
    if (!got || lat != 9) begin
      failures++;
      $display("FAIL rd_latency: got=%0d lat=%0d want 9", got, lat);
    end
    checks++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp: data=%h err=%b want 12345678/0", rd, er);
    end
    checks++;
    if (log_q.size() != 3 || log_q[0] !== w0 || log_q[1] !== r0 || log_q[2] !== r1) begin
      failures++;
      $display("FAIL rd_bus: n=%0d first=%h want 3 txns starting %h", log_q.size(),
               (log_q.size() != 0) ? log_q[0] : 34'h0, w0);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_req_busy !== 1'b0 || o_rsp_stb !== 1'b0 || o_rsp_data !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_after: busy=%b stb=%b data=%h want 0/0/12345678", o_req_busy, o_rsp_stb, o_rsp_data);
    end
  endtask

  task automatic test_reg_write_stall();
    logic [31:0] rd; logic er; int lat; bit got; int bad;
    txn_t w0, w1;
    w0 = '{we: 1'b1, addr: 1'b0, data: 32'h41F};
    w1 = '{we: 1'b1, addr: 1'b1, data: 32'hDEADBEEF};
    status_q.delete(); status_q.push_back(32'h200);
    cfg_stall = 3;
    do_req(2'b01, 5'h1F, 32'hDEADBEEF, rd, er, lat, got);
    cfg_stall = 0;
    checks++;
    if (!got || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp: got=%0d data=%h err=%b want 1/0/0", got, rd, er);
    end
    checks++;
    if (log_q.size() != 3 || log_q[0] !== w0 || log_q[2] !== w1) begin
      failures++;
      $display("FAIL wr_bus: n=%0d last=%h want 3 txns ending %h", log_q.size(),
               (log_q.size() != 0) ? log_q[log_q.size()-1] : 34'h0, w1);
    end
    bad = 0;
    foreach (stb_len_q[i]) if (stb_len_q[i] != 4) bad++;
    checks++;
    if (bad != 0 || stb_len_q.size() != 3) begin
      failures++;
      $display("FAIL wr_stb_len: %0d of %0d accesses not 4 cycles", bad, stb_len_q.size());
    end
  endtask

  task automatic test_poll_limit();
    logic [31:0] rd; logic er; int lat; bit got; int polls, data_acc;
    status_q.delete();
    repeat (20) status_q.push_back(32'h400);
    do_req(2'b00, 5'd3, 32'h0, rd, er, lat, got);
    polls = 0; data_acc = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].we && !log_q[i].addr) polls++;
      if (log_q[i].addr) data_acc++;
    end
    checks++;
    if (!got || er !== 1'b1) begin
      failures++;
      $display("FAIL poll_err: got=%0d err=%b want 1/1", got, er);
    end
    checks++;
    if (polls != POLL_LIMIT || data_acc != 0) begin
      failures++;
      $display("FAIL poll_count: polls=%0d data_acc=%0d want %0d/0", polls, data_acc, POLL_LIMIT);
    end
    status_q.delete();
  endtask

  task automatic test_ack_timeout();
    logic [31:0] rd; logic er; int lat; bit got;
    cfg_noack = 1'b1;
    do_req(2'b00, 5'd1, 32'h0, rd, er, lat, got);
    cfg_noack = 1'b0;
    checks++;
    if (!got || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL to_rsp: got=%0d err=%b data=%h want 1/1/0", got, er, rd);
    end
    checks++;
    if (last_cyc_run != ACK_TIMEOUT || log_q.size() != 1) begin
      failures++;
      $display("FAIL to_cyc: cyc_run=%0d accesses=%0d want %0d/1", last_cyc_run, log_q.size(), ACK_TIMEOUT);
    end
    checks++;
    if (o_req_busy !== 1'b1) begin
      failures++;
      $display("FAIL to_busy_rsp: busy=%b want 1 during rsp", o_req_busy);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_req_busy !== 1'b0 || o_dbg_cyc !== 1'b0) begin
      failures++;
      $display("FAIL to_busy_clr: busy=%b cyc=%b want 0/0", o_req_busy, o_dbg_cyc);
    end
  endtask

  task automatic test_raw_write_busy();
    int n0, n; bit got; logic [31:0] rd; logic er;
    txn_t w0;
    w0 = '{we: 1'b1, addr: 1'b0, data: 32'h0};
    n0 = rsp_count; got = 1'b0; rd = '0; er = 1'b0;
    log_q.delete();
    i_req_op = 2'b10; i_req_reg = '0; i_req_data = 32'h0; i_req_stb = 1'b1;
    @(posedge i_clk); #1;
    i_req_stb = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_req_busy !== 1'b1) begin
      failures++;
      $display("FAIL raw_busy: busy=%b want 1", o_req_busy);
    end
    i_req_op = 2'b11; i_req_stb = 1'b1;
    @(posedge i_clk); #1;
    i_req_stb = 1'b0;
    if (o_rsp_stb) begin got = 1'b1; rd = o_rsp_data; er = o_rsp_err; end
    n = 0;
    while (!got && n < 100) begin
      @(posedge i_clk); #1; n++;
      if (o_rsp_stb) begin got = 1'b1; rd = o_rsp_data; er = o_rsp_err; end
    end
    // request in the response cycle must be ignored too
    i_req_op = 2'b11; i_req_stb = 1'b1;
    @(posedge i_clk); #1;
    i_req_stb = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    checks++;
    if (!got || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL raw_rsp: got=%0d data=%h err=%b want 1/0/0", got, rd, er);
    end
    checks++;
    if (log_q.size() != 1 || log_q[0] !== w0) begin
      failures++;
      $display("FAIL raw_bus: n=%0d first=%h want 1 txn %h", log_q.size(),
               (log_q.size() != 0) ? log_q[0] : 34'h0, w0);
    end
    checks++;
    if (rsp_count - n0 != 1) begin
      failures++;
      $display("FAIL raw_single_rsp: responses=%0d want 1", rsp_count - n0);
    end
  endtask

  task automatic test_reset_in_poll();
    int n0, n; bit seen; logic [31:0] rd; logic er; int lat; bit got;
    status_q.delete();
    repeat (100) status_q.push_back(32'h400);
    n0 = rsp_count; seen = 1'b0;
    i_req_op = 2'b00; i_req_reg = 5'd2; i_req_data = '0; i_req_stb = 1'b1;
    @(posedge i_clk); #1;
    i_req_stb = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(posedge i_clk); #1; n++;
      if (o_dbg_cyc && !o_dbg_we && !o_dbg_addr) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_poll_seen: no poll read within 100 cycles");
    end
    #3;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_dbg_cyc !== 1'b0 || o_dbg_stb !== 1'b0 || o_req_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: cyc=%b stb=%b busy=%b want 000", o_dbg_cyc, o_dbg_stb, o_req_busy);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (rsp_count != n0) begin
      failures++;
      $display("FAIL rst_no_rsp: responses=%0d want 0", rsp_count - n0);
    end
    status_q.delete(); status_q.push_back(32'h0000_0A5A);
    do_req(2'b11, 5'd0, 32'h0, rd, er, lat, got);
    checks++;
    if (!got || lat != 4 || rd !== 32'h0000_0A5A || er !== 1'b0) begin
      failures++;
      $display("FAIL rst_stat_rd: got=%0d lat=%0d data=%h err=%b want 1/4/00000a5a/0", got, lat, rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit got; int nfail, bad;
    logic [1:0] op; logic [4:0] rg; logic [31:0] d;
    for (int it = 0; it < 24; it++) begin
      op = 2'($urandom_range(0, 3));
      rg = 5'($urandom_range(0, 31));
      d  = $urandom;
      cfg_data1 = $urandom;
      cfg_stall = $urandom_range(0, 2);
      nfail = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 3);
      status_q.delete();
      for (int k = 0; k < nfail; k++) status_q.push_back($urandom & ~32'h200);
      status_q.push_back($urandom | 32'h200);
      build_expect(op, rg, d, cfg_data1);
      do_req(op, rg, d, rd, er, lat, got);
      checks++;
      if (!got || rd !== exp_data || er !== exp_err) begin
        failures++;
        $display("FAIL rand_rsp[%0d] op=%0d: got=%0d data=%h err=%b want %h/%b",
                 it, op, got, rd, er, exp_data, exp_err);
      end
      bad = (log_q.size() != exp_q.size()) ? 1 : 0;
      if (bad == 0) foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_bus[%0d] op=%0d: %0d txns want %0d (or content differs)",
                 it, op, log_q.size(), exp_q.size());
      end
    end
    cfg_stall = 0;
    status_q.delete();
    checks++;
    if (gap_err != 0) begin
      failures++;
      $display("FAIL cyc_gap: %0d accesses started without an idle cyc cycle", gap_err);
    end
  endtask

  initial begin
    test_reset();
    test_reg_read();
    test_reg_write_stall();
    test_poll_limit();
    test_ack_timeout();
    test_raw_write_busy();
    test_reset_in_poll();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
